// File: rtl/aes_keyex_pkg.sv
// Shared types, mode table, rcon table and word helpers for the AES key expander.
package aes_keyex_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned RK_W        = 128;
    localparam int unsigned NUM_RK      = 15;
    localparam int unsigned NUM_WORDS   = 4 * NUM_RK;
    localparam int unsigned CHUNK_WORDS = 8;

    typedef enum logic [1:0] {
        MODE_128 = 2'd0,
        MODE_192 = 2'd1,
        MODE_256 = 2'd2,
        MODE_BAD = 2'd3
    } key_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } kx_state_e;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [CHUNK_WORDS-1:0] chunk_t;

    function automatic int unsigned nk_of(input key_mode_e m);
        case (m)
            MODE_192: return 6;
            MODE_256: return 8;
            default:  return 4;
        endcase
    endfunction

    function automatic int unsigned nr_of(input key_mode_e m);
        case (m)
            MODE_192: return 12;
            MODE_256: return 14;
            default:  return 10;
        endcase
    endfunction

    function automatic logic [3:0] nstep_of(input key_mode_e m);
        case (m)
            MODE_192: return 4'd8;
            MODE_256: return 4'd7;
            default:  return 4'd10;
        endcase
    endfunction

    function automatic int unsigned nwords_of(input key_mode_e m);
        return 4 * (nr_of(m) + 1);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_keyex_step.sv
// Combinational generator of one Nk-word chunk of the key schedule.
module aes_keyex_step
    import aes_keyex_pkg::*;
(
    input  chunk_t          i_prev,
    input  key_mode_e       i_mode,
    input  logic [7:0]      i_rcon,
    input  logic [63:0]     i_sbox_dout,
    output chunk_t          o_next,
    output logic [63:0]     o_sbox_din
);

    // Lanes and word halves are kept as separate signals so the chained
    // lane0 -> n3 -> lane1 path through the external S-box is not a loop.
    word_t               lane0;
    word_t               lane1;
    logic [3:0][31:0]    lo;
    logic [3:0][31:0]    hi;

    // lane0 feeds the last word of the previous chunk, rotated
    always_comb begin
        lane0 = '0;
        case (i_mode)
            MODE_192: lane0 = rot_word(i_prev[5]);
            MODE_256: lane0 = rot_word(i_prev[7]);
            default:  lane0 = rot_word(i_prev[3]);
        endcase
    end

    // words 0..3 of the new chunk: present in every mode
    always_comb begin
        lo    = '0;
        lo[0] = i_prev[0] ^ i_sbox_dout[31:0] ^ {i_rcon, 24'h0};
        lo[1] = i_prev[1] ^ lo[0];
        lo[2] = i_prev[2] ^ lo[1];
        lo[3] = i_prev[3] ^ lo[2];
    end

    assign lane1 = (i_mode == MODE_256) ? lo[3] : '0;

    // words 4..7: plain chaining for 192, SubWord restart at word 4 for 256
    always_comb begin
        hi = '0;
        if (i_mode == MODE_192) begin
            hi[0] = i_prev[4] ^ lo[3];
            hi[1] = i_prev[5] ^ hi[0];
        end else if (i_mode == MODE_256) begin
            hi[0] = i_prev[4] ^ i_sbox_dout[63:32];
            hi[1] = i_prev[5] ^ hi[0];
            hi[2] = i_prev[6] ^ hi[1];
            hi[3] = i_prev[7] ^ hi[2];
        end
    end

    assign o_next     = {hi, lo};
    assign o_sbox_din = {lane1, lane0};

endmodule

// File: rtl/aes_keyex_multi.sv
// Iterative AES-128/192/256 key expander: one chunk per cycle, full schedule bus and read port.
module aes_keyex_multi
    import aes_keyex_pkg::*;
#(
    parameter int DLY     = 1,
    parameter bit RK_PORT = 1'b1
)
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [255:0]    i_key,
    input  logic [1:0]      i_mode,
    input  logic            i_key_en,
    output logic            o_busy,
    output logic            o_key_ok,
    output logic            o_err,
    output logic [1919:0]   o_exkey,
    input  logic [3:0]      i_rk_idx,
    output logic [127:0]    o_rkey,
    output logic            o_sbox_use,
    output logic [63:0]     o_sbox_din,
    input  logic [63:0]     i_sbox_dout
);

    // DLY is kept for drop-in compatibility; registers are modelled without delay.
    if (DLY < 0) begin : g_dly_unused
    end

    key_mode_e                          in_mode;
    key_mode_e                          mode_q;
    key_mode_e                          step_mode;
    kx_state_e                          st_q;
    kx_state_e                          st_d;
    logic                               start;
    logic                               bad;
    logic                               busy;
    logic                               last;
    logic [3:0]                         cnt_q;
    logic [7:0]                         step_rcon;
    logic                               key_ok_q;
    logic                               err_q;
    chunk_t                             key_chunk;
    chunk_t                             prev_q;
    chunk_t                             step_prev;
    chunk_t                             step_next;
    logic [NUM_WORDS-1:0][WORD_W-1:0]   wst_q;
    logic [NUM_WORDS-1:0][WORD_W-1:0]   wst_d;
    logic [0:NUM_RK-1][RK_W-1:0]        rk_arr;

    assign in_mode   = key_mode_e'(i_mode);
    assign start     = i_key_en & (in_mode != MODE_BAD);
    assign bad       = i_key_en & (in_mode == MODE_BAD);
    assign busy      = (st_q == ST_RUN);
    assign last      = (cnt_q == nstep_of(mode_q));

    // split the MSB-aligned key into words, w0 from the top
    always_comb begin
        key_chunk = '0;
        for (int unsigned i = 0; i < CHUNK_WORDS; i++) begin
            key_chunk[3'(i)] = i_key[255 - 32*i -: 32];
        end
    end

    // on a start the step works straight from i_key, otherwise from the last chunk
    assign step_mode = start ? in_mode   : mode_q;
    assign step_prev = start ? key_chunk : prev_q;
    assign step_rcon = rcon_of(start ? 4'd0 : (cnt_q - 4'd1));

    aes_keyex_step u_step (
        .i_prev      (step_prev),
        .i_mode      (step_mode),
        .i_rcon      (step_rcon),
        .i_sbox_dout (i_sbox_dout),
        .o_next      (step_next),
        .o_sbox_din  (o_sbox_din)
    );

    // idle/run state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) st_q <= ST_IDLE;
        else          st_q <= st_d;
    end

    // a legal start always (re)enters RUN; RUN ends after the last step
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: if (start) st_d = ST_RUN;
            ST_RUN:  if (!start && last) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    // next word-store contents: key + chunk 1 on start, chunk cnt while running
    always_comb begin
        int unsigned idx;
        idx   = 0;
        wst_d = wst_q;
        if (start) begin
            for (int unsigned i = 0; i < CHUNK_WORDS; i++) begin
                if (i < nk_of(in_mode)) begin
                    wst_d[6'(i)]                  = key_chunk[3'(i)];
                    wst_d[6'(nk_of(in_mode) + i)] = step_next[3'(i)];
                end
            end
        end else if (busy) begin
            for (int unsigned i = 0; i < CHUNK_WORDS; i++) begin
                idx = 32'(cnt_q) * nk_of(mode_q) + i;
                if (i < nk_of(mode_q) && idx < nwords_of(mode_q)) begin
                    wst_d[6'(idx)] = step_next[3'(i)];
                end
            end
        end
    end

    // word store, chunk pipeline, step counter, mode and status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wst_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_128;
            key_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wst_q <= wst_d;
            err_q <= bad;
            if (start) begin
                prev_q   <= step_next;
                cnt_q    <= 4'd2;
                mode_q   <= in_mode;
                key_ok_q <= 1'b0;
            end else if (busy) begin
                prev_q <= step_next;
                if (last) key_ok_q <= 1'b1;
                else      cnt_q    <= cnt_q + 4'd1;
            end
        end
    end

    // round keys beyond Nr read as zero, hiding words from a longer earlier key
    always_comb begin
        rk_arr = '0;
        for (int unsigned r = 0; r < NUM_RK; r++) begin
            if (r <= nr_of(mode_q)) begin
                rk_arr[4'(r)] = {wst_q[6'(4*r)],   wst_q[6'(4*r+1)],
                                 wst_q[6'(4*r+2)], wst_q[6'(4*r+3)]};
            end
        end
    end

    assign o_exkey    = rk_arr;
    assign o_busy     = busy;
    assign o_key_ok   = key_ok_q & ~start;
    assign o_err      = err_q;
    assign o_sbox_use = busy | start;

    if (RK_PORT) begin : g_rk_port
        logic [RK_W-1:0] rkey_q;

        // registered single round-key read, every cycle
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)                   rkey_q <= '0;
            else if (i_rk_idx < 4'(NUM_RK)) rkey_q <= rk_arr[i_rk_idx];
            else                            rkey_q <= '0;
        end

        assign o_rkey = rkey_q;
    end else begin : g_no_rk_port
        assign o_rkey = '0;
    end

endmodule

// File: tb/tb_aes_keyex_multi.sv
// Directed bench for aes_keyex_multi with a combinational S-box model and FIPS-197 vectors.
module tb_aes_keyex_multi;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [255:0]    i_key;
    logic [1:0]      i_mode;
    logic            i_key_en;
    logic            o_busy;
    logic            o_key_ok;
    logic            o_err;
    logic [1919:0]   o_exkey;
    logic [3:0]      i_rk_idx;
    logic [127:0]    o_rkey;
    logic            o_sbox_use;
    logic [63:0]     sbox_din;
    logic [31:0]     dout0;
    logic [31:0]     dout1;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] JUNK = 256'hdeadbeef_0badf00d_12345678_9abcdef0_cafebabe_55aa55aa_0f0f0f0f_f0f0f0f0;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    int uses;
    logic [1919:0] m128, m192, m256;

    always #5 i_clk = ~i_clk;

    aes_keyex_multi #(.DLY(1), .RK_PORT(1'b1)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_key       (i_key),
        .i_mode      (i_mode),
        .i_key_en    (i_key_en),
        .o_busy      (o_busy),
        .o_key_ok    (o_key_ok),
        .o_err       (o_err),
        .o_exkey     (o_exkey),
        .i_rk_idx    (i_rk_idx),
        .o_rkey      (o_rkey),
        .o_sbox_use  (o_sbox_use),
        .o_sbox_din  (sbox_din),
        .i_sbox_dout ({dout1, dout0})
    );

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] sbox_b(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_b(w[31:24]), sbox_b(w[23:16]), sbox_b(w[15:8]), sbox_b(w[7:0])};
    endfunction

    assign dout0 = sub_word(sbox_din[31:0]);
    assign dout1 = sub_word(sbox_din[63:32]);

    // word-at-a-time FIPS-197 expansion, rounds beyond Nr left at zero
    function automatic logic [1919:0] model_exp(input logic [255:0] key, input int mode);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] res = '0;
        int nk = (mode == 0) ? 4 : (mode == 1) ? 6 : 8;
        int nw = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) res[1919 - 32*i -: 32] = w[i];
        return res;
    endfunction

    function automatic logic [127:0] rk_of(input logic [1919:0] x, input int r);
        return x[1919 - 128*r -: 128];
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic cmp_all(input string pfx, input logic [1919:0] exp);
        for (int r = 0; r < 15; r++)
            chk($sformatf("%s_rk%0d", pfx, r), rk_of(o_exkey, r), rk_of(exp, r));
    endtask

    // entered just after a posedge of cycle first; returns the cycle o_key_ok is seen
    task automatic wait_ok(input int first, output int c);
        c = first;
        @(negedge i_clk);
        while (!o_key_ok && c < 40) begin
            @(negedge i_clk);
            c++;
        end
    endtask

    task automatic load(input logic [255:0] key, input logic [1:0] mode);
        @(posedge i_clk); #1;
        i_key = key; i_mode = mode; i_key_en = 1'b1;
    endtask

    task automatic release_en();
        @(posedge i_clk); #1;
        i_key_en = 1'b0; i_key = JUNK; i_mode = 2'd2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        m128 = model_exp(K128, 0);
        m192 = model_exp(K192, 1);
        m256 = model_exp(K256, 2);
        i_rst_n = 1'b0; i_key = '0; i_mode = 2'd0; i_key_en = 1'b0; i_rk_idx = 4'd0;

        #7;
        chk("rst_busy",  128'(o_busy),     128'(0));
        chk("rst_ok",    128'(o_key_ok),   128'(0));
        chk("rst_err",   128'(o_err),      128'(0));
        chk("rst_use",   128'(o_sbox_use), 128'(0));
        chk("rst_rkey",  o_rkey,           128'(0));
        chk("rst_rk0",   rk_of(o_exkey, 0),  128'(0));
        chk("rst_rk10",  rk_of(o_exkey, 10), 128'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // AES-128
        load(K128, 2'd0);
        @(negedge i_clk);
        chk("use_T128", 128'(o_sbox_use), 128'(1));
        chk("din_T128", 128'(sbox_din),   128'({32'h0, 32'hcf4f3c09}));
        chk("busy_T128", 128'(o_busy),    128'(0));
        release_en();
        wait_ok(1, cyc);
        chk("lat128",    128'(cyc),    128'(10));
        chk("idle128",   128'(o_busy), 128'(0));
        chk("rk10_128",  rk_of(o_exkey, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        cmp_all("a128", m128);

        // AES-192 and read-port sweep
        load(K192, 2'd1);
        @(negedge i_clk);
        chk("din_T192", 128'(sbox_din), 128'({32'h0, 32'h2c6b7b52}));
        release_en();
        wait_ok(1, cyc);
        chk("lat192",   128'(cyc), 128'(8));
        chk("rk12_192", rk_of(o_exkey, 12), 128'he98ba06f448c773c8ecc720401002202);
        cmp_all("a192", m192);
        for (int idx = 0; idx < 16; idx++) begin
            @(negedge i_clk);
            i_rk_idx = 4'(idx);
            @(negedge i_clk);
            chk($sformatf("rport%0d", idx), o_rkey, (idx <= 12) ? rk_of(m192, idx) : 128'h0);
        end

        // AES-256 with S-box claim count over T..T+7
        load(K256, 2'd2);
        @(negedge i_clk);
        chk("din_T256_l0", 128'(sbox_din[31:0]), 128'(32'h14dff409));
        uses = int'(o_sbox_use);
        release_en();
        cyc = 1;
        @(negedge i_clk);
        uses += int'(o_sbox_use);
        while (!o_key_ok && cyc < 40) begin
            @(negedge i_clk);
            cyc++;
            uses += int'(o_sbox_use);
        end
        chk("lat256",   128'(cyc),  128'(7));
        chk("uses256",  128'(uses), 128'(7));
        chk("rk14_256", rk_of(o_exkey, 14), 128'hfe4890d1e6188d0b046df344706c631e);
        cmp_all("a256", m256);

        // restart: 256 at T, 128 at T+3, key changes afterwards
        load(K256, 2'd2);
        release_en();
        @(posedge i_clk); #1;
        load(K128, 2'd0);
        @(negedge i_clk);
        chk("restart_busy", 128'(o_busy), 128'(1));
        release_en();
        wait_ok(4, cyc);
        chk("lat_restart", 128'(cyc), 128'(13));
        cmp_all("re128", m128);

        // illegal mode while idle
        load(K256, 2'd3);
        release_en();
        @(negedge i_clk);
        chk("bad_err",  128'(o_err),    128'(1));
        chk("bad_ok",   128'(o_key_ok), 128'(1));
        chk("bad_busy", 128'(o_busy),   128'(0));
        @(negedge i_clk);
        chk("bad_err_clr", 128'(o_err), 128'(0));
        cmp_all("bad128", m128);

        // illegal mode during a 192 expansion: expansion carries on
        load(K192, 2'd1);
        release_en();
        load(JUNK, 2'd3);
        release_en();
        @(negedge i_clk);
        chk("badrun_err",  128'(o_err),  128'(1));
        chk("badrun_busy", 128'(o_busy), 128'(1));
        cyc = 3;
        while (!o_key_ok && cyc < 40) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("lat_badrun", 128'(cyc), 128'(8));
        cmp_all("br192", m192);

        // asynchronous reset mid-expansion
        i_rk_idx = 4'd0;
        load(K256, 2'd2);
        release_en();
        @(posedge i_clk); #3;
        chk("pre_rst_busy", 128'(o_busy), 128'(1));
        i_rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(o_busy),     128'(0));
        chk("arst_ok",   128'(o_key_ok),   128'(0));
        chk("arst_err",  128'(o_err),      128'(0));
        chk("arst_use",  128'(o_sbox_use), 128'(0));
        chk("arst_rkey", o_rkey,           128'(0));
        chk("arst_rk0",  rk_of(o_exkey, 0), 128'(0));
        #10;
        i_rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
